// File: rtl/bus_responder_6502.sv
// rtl/bus_responder_6502.sv - 6502C bus RAM responder with programmable read wait states
module bus_responder_6502 #(
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        RES_L,
  input  logic [15:0] extAB,
  input  logic        RW,
  input  logic        SYNC,
  input  logic [7:0]  dataIn,
  output logic [7:0]  dataOut,
  output logic        dataOE,
  output logic        RDY,
  output logic        hit,
  output logic [15:0] opFetchCount,
  output logic        protoErr
);

  localparam int             DEPTH       = 1 << ADDR_BITS;
  localparam int             WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0]     WAIT_INIT   = WAIT_INIT_I[2:0];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            lat_addr_q, lat_addr_d;
  logic [2:0]             wait_cnt_q, wait_cnt_d;
  logic                   rdy_q, rdy_d;
  logic                   oe_q, oe_d;
  logic [7:0]             dout_q, dout_d;
  logic                   perr_q, perr_d;
  logic [15:0]            fetch_cnt_q;
  logic [7:0]             mem [DEPTH];
  logic [ADDR_BITS-1:0]   idx;
  logic [ADDR_BITS-1:0]   lat_idx;
  logic                   fetch_seen;

  assign hit        = (extAB[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign idx        = extAB[ADDR_BITS-1:0];
  assign lat_idx    = lat_addr_q[ADDR_BITS-1:0];
  // A fetch counts only on a cycle the CPU actually completed, so a stalled fetch counts once.
  assign fetch_seen = SYNC && RW && rdy_q;

  assign dataOut      = dout_q;
  assign dataOE       = oe_q;
  assign RDY          = rdy_q;
  assign opFetchCount = fetch_cnt_q;
  assign protoErr     = perr_q;

  // RAM write port; contents survive reset, and non-blocking update gives read-before-write.
  always_ff @(posedge clock) begin
    if (RES_L && hit && !RW) begin
      mem[idx] <= dataIn;
    end
  end

  // Bus-cycle state register and registered bus outputs.
  always_ff @(posedge clock or negedge RES_L) begin
    if (!RES_L) begin
      state_q     <= ST_IDLE;
      lat_addr_q  <= 16'h0000;
      wait_cnt_q  <= 3'd0;
      rdy_q       <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= 8'h00;
      perr_q      <= 1'b0;
      fetch_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      wait_cnt_q  <= wait_cnt_d;
      rdy_q       <= rdy_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      perr_q      <= perr_d;
      if (fetch_seen) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  // Next-state decode: start/finish reads, count wait states, flag address changes during a stall.
  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    wait_cnt_d = wait_cnt_q;
    rdy_d      = rdy_q;
    oe_d       = 1'b0;
    dout_d     = dout_q;
    perr_d     = perr_q;
    case (state_q)
      ST_WAIT: begin
        if (RW) begin
          if (extAB != lat_addr_q) begin
            perr_d  = 1'b1;
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (wait_cnt_q != 3'd0) begin
            wait_cnt_d = wait_cnt_q - 3'd1;
          end else begin
            rdy_d   = 1'b1;
            dout_d  = mem[lat_idx];
            oe_d    = 1'b1;
            state_d = ST_DATA;
          end
        end
        // Write cycles during a stall leave the wait untouched; the RAM port handles the data.
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
        if (hit && RW) begin
          if (WAIT_STATES == 0) begin
            dout_d  = mem[idx];
            oe_d    = 1'b1;
            state_d = ST_DATA;
          end else begin
            lat_addr_d = extAB;
            rdy_d      = 1'b0;
            wait_cnt_d = WAIT_INIT;
            state_d    = ST_WAIT;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bus_responder_6502.sv
// tb/tb_bus_responder_6502.sv - directed scoreboard bench for bus_responder_6502
module tb_bus_responder_6502;

  localparam int          N      = 3;
  localparam logic [15:0] IDLE_A = 16'hF000;

  logic        clock = 1'b0;
  logic        res_l;
  logic [15:0] ab   [N];
  logic        rw   [N];
  logic        sync [N];
  logic [7:0]  din  [N];
  logic [7:0]  dout [N];
  logic        oe   [N];
  logic        rdy  [N];
  logic        hit  [N];
  logic [15:0] ofc  [N];
  logic        perr [N];

  logic [7:0]  model [N][256];
  logic [7:0]  exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          low;

  always #5 clock = ~clock;

  bus_responder_6502 #(.BASE_ADDR(16'h0200), .ADDR_BITS(8), .WAIT_STATES(0)) u_w0 (
    .clock(clock), .RES_L(res_l), .extAB(ab[0]), .RW(rw[0]), .SYNC(sync[0]), .dataIn(din[0]),
    .dataOut(dout[0]), .dataOE(oe[0]), .RDY(rdy[0]), .hit(hit[0]), .opFetchCount(ofc[0]), .protoErr(perr[0])
  );

  bus_responder_6502 #(.BASE_ADDR(16'h0200), .ADDR_BITS(8), .WAIT_STATES(2)) u_w2 (
    .clock(clock), .RES_L(res_l), .extAB(ab[1]), .RW(rw[1]), .SYNC(sync[1]), .dataIn(din[1]),
    .dataOut(dout[1]), .dataOE(oe[1]), .RDY(rdy[1]), .hit(hit[1]), .opFetchCount(ofc[1]), .protoErr(perr[1])
  );

  bus_responder_6502 #(.BASE_ADDR(16'h0200), .ADDR_BITS(8), .WAIT_STATES(3)) u_w3 (
    .clock(clock), .RES_L(res_l), .extAB(ab[2]), .RW(rw[2]), .SYNC(sync[2]), .dataIn(din[2]),
    .dataOut(dout[2]), .dataOE(oe[2]), .RDY(rdy[2]), .hit(hit[2]), .opFetchCount(ofc[2]), .protoErr(perr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One bus cycle on unit u; outputs sampled 1 ns after the edge, read data drained from the scoreboard.
  task automatic step(input int u, input logic [15:0] a, input logic r, input logic s, input logic [7:0] d);
    ab[u] = a; rw[u] = r; sync[u] = s; din[u] = d;
    @(posedge clock);
    #1;
    if (oe[u] === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_oe", 32'(oe[u]), 32'd0);
      else check("read_data", 32'(dout[u]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wr(input int u, input logic [15:0] a, input logic [7:0] d);
    if (a[15:8] == 8'h02) model[u][a[7:0]] = d;
    step(u, a, 1'b0, 1'b0, d);
  endtask

  // Issue a read held steady until RDY returns; reports how many sampled cycles RDY was low.
  task automatic rd_wait(input int u, input logic [15:0] a, input logic s, output int lo);
    lo = 0;
    if (a[15:8] == 8'h02) exp_q.push_back(model[u][a[7:0]]);
    step(u, a, 1'b1, s, 8'h00);
    for (int i = 0; i < 12 && rdy[u] == 1'b0; i++) begin
      lo++;
      step(u, a, 1'b1, s, 8'h00);
    end
    check("rd_rdy_back", 32'(rdy[u]), 32'd1);
  endtask

  initial begin
    res_l = 1'b1;
    for (int u = 0; u < N; u++) begin
      ab[u] = IDLE_A; rw[u] = 1'b1; sync[u] = 1'b0; din[u] = 8'h00;
    end
    #2 res_l = 1'b0;
    #1;
    for (int u = 0; u < N; u++) begin
      check("rst_rdy",  32'(rdy[u]),  32'd1);
      check("rst_oe",   32'(oe[u]),   32'd0);
      check("rst_dout", 32'(dout[u]), 32'd0);
      check("rst_ofc",  32'(ofc[u]),  32'd0);
      check("rst_perr", 32'(perr[u]), 32'd0);
      check("rst_hit",  32'(hit[u]),  32'd0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) res_l = 1'b1;

    // 1: two wait states, write then held read
    wr(1, 16'h0210, 8'hA5);
    check("t1_wr_rdy", 32'(rdy[1]), 32'd1);
    check("t1_wr_oe",  32'(oe[1]),  32'd0);
    rd_wait(1, 16'h0210, 1'b0, low);
    check("t1_low_cycles", 32'(low), 32'd2);
    check("t1_oe", 32'(oe[1]), 32'd1);
    step(1, IDLE_A, 1'b1, 1'b0, 8'h00);
    check("t1_oe_drop", 32'(oe[1]), 32'd0);
    check("t1_perr", 32'(perr[1]), 32'd0);

    // 2: zero wait states, back-to-back reads
    wr(0, 16'h0200, 8'h11);
    wr(0, 16'h0201, 8'h22);
    exp_q.push_back(model[0][8'h00]);
    step(0, 16'h0200, 1'b1, 1'b0, 8'h00);
    check("t2_oe0", 32'(oe[0]), 32'd1);
    check("t2_rdy0", 32'(rdy[0]), 32'd1);
    exp_q.push_back(model[0][8'h01]);
    step(0, 16'h0201, 1'b1, 1'b0, 8'h00);
    check("t2_oe1", 32'(oe[0]), 32'd1);
    check("t2_rdy1", 32'(rdy[0]), 32'd1);
    step(0, IDLE_A, 1'b1, 1'b0, 8'h00);
    check("t2_oe_drop", 32'(oe[0]), 32'd0);

    // 3: misses do not touch the window
    step(0, 16'h0300, 1'b1, 1'b0, 8'h00);
    check("t3_hit_rd", 32'(hit[0]), 32'd0);
    check("t3_rdy_rd", 32'(rdy[0]), 32'd1);
    check("t3_oe_rd",  32'(oe[0]),  32'd0);
    wr(0, 16'h0300, 8'hEE);
    check("t3_hit_wr", 32'(hit[0]), 32'd0);
    check("t3_oe_wr",  32'(oe[0]),  32'd0);
    exp_q.push_back(model[0][8'h00]);
    step(0, 16'h0200, 1'b1, 1'b0, 8'h00);
    check("t3_hit_win", 32'(hit[0]), 32'd1);
    check("t3_oe_win",  32'(oe[0]),  32'd1);
    step(0, IDLE_A, 1'b1, 1'b0, 8'h00);

    // 4: three wait states, address changes in second wait cycle
    wr(2, 16'h0205, 8'h5A);
    step(2, 16'h0205, 1'b1, 1'b0, 8'h00);
    check("t4_rdy_w1", 32'(rdy[2]), 32'd0);
    step(2, 16'h0205, 1'b1, 1'b0, 8'h00);
    check("t4_rdy_w2", 32'(rdy[2]), 32'd0);
    check("t4_perr_pre", 32'(perr[2]), 32'd0);
    step(2, 16'h0206, 1'b1, 1'b0, 8'h00);
    check("t4_perr", 32'(perr[2]), 32'd1);
    check("t4_rdy",  32'(rdy[2]),  32'd1);
    check("t4_oe",   32'(oe[2]),   32'd0);
    repeat (3) step(2, IDLE_A, 1'b1, 1'b0, 8'h00);
    check("t4_perr_sticky", 32'(perr[2]), 32'd1);

    // 5: async reset in the middle of a wait
    step(1, 16'h0210, 1'b1, 1'b1, 8'h00);
    check("t5_rdy_wait", 32'(rdy[1]), 32'd0);
    check("t5_ofc_pre",  32'(ofc[1]), 32'd1);
    step(1, 16'h0210, 1'b1, 1'b1, 8'h00);
    #2 res_l = 1'b0;
    #1;
    check("t5_rdy", 32'(rdy[1]), 32'd1);
    check("t5_oe",  32'(oe[1]),  32'd0);
    check("t5_ofc", 32'(ofc[1]), 32'd0);
    check("t5_dout", 32'(dout[1]), 32'd0);
    check("t5_perr_clr", 32'(perr[2]), 32'd0);
    ab[1] = IDLE_A; sync[1] = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) res_l = 1'b1;
    step(1, IDLE_A, 1'b1, 1'b0, 8'h00);
    check("t5_no_oe", 32'(oe[1]), 32'd0);
    rd_wait(1, 16'h0210, 1'b0, low);
    check("t5_low_cycles", 32'(low), 32'd2);
    step(1, IDLE_A, 1'b1, 1'b0, 8'h00);

    // 6: opcode fetch counter wrap, including one stalled fetch
    check("t6_ofc_start", 32'(ofc[1]), 32'd0);
    for (int i = 0; i < 65533; i++) step(1, IDLE_A, 1'b1, 1'b1, 8'h00);
    check("t6_ofc_fffd", 32'(ofc[1]), 32'h0000FFFD);
    rd_wait(1, 16'h0210, 1'b1, low);
    check("t6_stall_low", 32'(low), 32'd2);
    check("t6_ofc_fffe", 32'(ofc[1]), 32'h0000FFFE);
    step(1, IDLE_A, 1'b1, 1'b1, 8'h00);
    check("t6_ofc_ffff", 32'(ofc[1]), 32'h0000FFFF);
    step(1, IDLE_A, 1'b1, 1'b1, 8'h00);
    check("t6_ofc_wrap", 32'(ofc[1]), 32'h00000000);
    step(1, IDLE_A, 1'b1, 1'b0, 8'h00);
    check("t6_ofc_hold", 32'(ofc[1]), 32'h00000000);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
